// File: rtl/sde_h2c_axis.sv
// -----------------------------------------------------------------------------
// sde_h2c_axis
//
// H2C AXI-Stream egress stage. Beats from the H2C data buffer are passed to the
// CL AXI-Stream master port through a two-entry skid buffer (head + skid), so
// the buffer-side ready is a flop output with no combinational path from the
// CL ready. Completed packets (last beat transferred to the CL) are counted.
// Each completed packet raises a one-cycle write-back request on the following
// cycle. By then the count outputs already hold the updated value.
//
// Optional build macro: SDE_H2C_AXIS_KEEP_CHECK_EN
//   When defined, every accepted input beat has its keep checked. A keep of
//   zero, a non-contiguous keep (not 2^n-1), or a non-full keep on a non-last
//   beat sets the sticky axis_cfg_keep_err flag. Beats are still forwarded
//   unchanged. When undefined, axis_cfg_keep_err is tied low.
//
// Ports:
//   clk, rst_n              clock, synchronous active-low reset
//   cfg_axis_clr_pkt_cnt    clear packet count and keep error
//   axis_cfg_pkt_cnt        packets delivered to the CL
//   axis_cfg_keep_err       sticky keep-format error
//   buf_axis_*              beat input from the H2C buffer (valid/ready)
//   h2c_axis_*              beat output to the CL (valid/ready)
//   axis_wb_pkt_cnt_req     one-cycle write-back request per completed packet
//   axis_wb_pkt_cnt         packet count for write-back
// -----------------------------------------------------------------------------
module sde_h2c_axis #(
    parameter int DESC_TYPE       = 0,
    parameter int PCIM_DATA_WIDTH = 512,
    parameter int AXIS_DATA_WIDTH = 512,
    parameter int USER_BIT_WIDTH  = (DESC_TYPE != 0) ? 1 : 64
) (
    input  logic                           clk,
    input  logic                           rst_n,

    input  logic                           cfg_axis_clr_pkt_cnt,
    output logic [31:0]                    axis_cfg_pkt_cnt,
    output logic                           axis_cfg_keep_err,

    input  logic                           buf_axis_valid,
    input  logic [PCIM_DATA_WIDTH-1:0]     buf_axis_data,
    input  logic [PCIM_DATA_WIDTH/8-1:0]   buf_axis_keep,
    input  logic [USER_BIT_WIDTH-1:0]      buf_axis_user,
    input  logic                           buf_axis_last,
    output logic                           axis_buf_ready,

    output logic                           h2c_axis_valid,
    output logic [AXIS_DATA_WIDTH-1:0]     h2c_axis_data,
    output logic [AXIS_DATA_WIDTH/8-1:0]   h2c_axis_keep,
    output logic [USER_BIT_WIDTH-1:0]      h2c_axis_user,
    output logic                           h2c_axis_last,
    input  logic                           h2c_axis_ready,

    output logic                           axis_wb_pkt_cnt_req,
    output logic [31:0]                    axis_wb_pkt_cnt
);

    localparam int KEEP_W = AXIS_DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    typedef struct packed {
        logic [AXIS_DATA_WIDTH-1:0] data;
        logic [KEEP_W-1:0]          keep;
        logic [USER_BIT_WIDTH-1:0]  user;
        logic                       last;
    } beat_t;

    state_e      state_q, state_d;
    beat_t       head_q, head_d;
    beat_t       skid_q, skid_d;
    beat_t       in_beat;
    logic        ready_q, ready_d;
    logic        accept;
    logic        xfer;
    logic [31:0] pkt_cnt_q, pkt_cnt_d;
    logic        wb_req_q, wb_req_d;

    assign in_beat = '{data: buf_axis_data,
                       keep: buf_axis_keep,
                       user: buf_axis_user,
                       last: buf_axis_last};

    assign accept = buf_axis_valid & ready_q;
    assign xfer   = (state_q != ST_EMPTY) & h2c_axis_ready;

    // Skid buffer next-state. Acceptance is only possible when ready_q is
    // set, which never happens in FULL, so FULL only has to handle drain.
    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept) begin
                    head_d  = in_beat;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept && !xfer) begin
                    skid_d  = in_beat;
                    state_d = ST_FULL;
                end else if (!accept && xfer) begin
                    state_d = ST_EMPTY;
                end else if (accept && xfer) begin
                    head_d  = in_beat;
                end
            end
            ST_FULL: begin
                if (xfer) begin
                    head_d  = skid_q;
                    state_d = ST_ONE;
                end
            end
            default: begin
                state_d = ST_EMPTY;
            end
        endcase
    end

    // Ready is registered from the next state: it depends on h2c_axis_ready
    // only through a flop, and stays low while reset is held.
    assign ready_d = (state_d != ST_FULL);

    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        if (cfg_axis_clr_pkt_cnt) begin
            pkt_cnt_d = '0;
        end else if (xfer && head_q.last) begin
            pkt_cnt_d = pkt_cnt_q + 32'd1;
        end
    end

    // The request follows every last transfer, even one cleared in the same
    // cycle, so write-back never misses a completed packet.
    assign wb_req_d = xfer & head_q.last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_EMPTY;
            ready_q   <= 1'b0;
            head_q    <= '0;
            skid_q    <= '0;
            pkt_cnt_q <= '0;
            wb_req_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ready_q   <= ready_d;
            head_q    <= head_d;
            skid_q    <= skid_d;
            pkt_cnt_q <= pkt_cnt_d;
            wb_req_q  <= wb_req_d;
        end
    end

    assign axis_buf_ready      = ready_q;
    assign h2c_axis_valid      = (state_q != ST_EMPTY);
    assign h2c_axis_data       = head_q.data;
    assign h2c_axis_keep       = head_q.keep;
    assign h2c_axis_user       = head_q.user;
    assign h2c_axis_last       = head_q.last;
    assign axis_cfg_pkt_cnt    = pkt_cnt_q;
    assign axis_wb_pkt_cnt     = pkt_cnt_q;
    assign axis_wb_pkt_cnt_req = wb_req_q;

`ifdef SDE_H2C_AXIS_KEEP_CHECK_EN
    localparam int IN_KEEP_W = PCIM_DATA_WIDTH / 8;
    localparam logic [IN_KEEP_W-1:0] KEEP_ONE = IN_KEEP_W'(1);

    logic keep_viol;
    logic keep_err_q;

    // keep & (keep + 1) is zero exactly for 2^n-1 patterns (including all
    // ones, which wraps to zero), i.e. bytes contiguous from byte 0.
    always_comb begin
        keep_viol = (buf_axis_keep == '0)
                 || ((buf_axis_keep & (buf_axis_keep + KEEP_ONE)) != '0)
                 || (!buf_axis_last && (buf_axis_keep != '1));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            keep_err_q <= 1'b0;
        end else if (cfg_axis_clr_pkt_cnt) begin
            keep_err_q <= 1'b0;
        end else if (accept && keep_viol) begin
            keep_err_q <= 1'b1;
        end
    end

    assign axis_cfg_keep_err = keep_err_q;
`else
    assign axis_cfg_keep_err = 1'b0;
`endif

endmodule

// File: tb/tb_sde_h2c_axis.sv
// -----------------------------------------------------------------------------
// tb_sde_h2c_axis
//
// Directed sequence plus a randomized section for sde_h2c_axis. A reference
// model tracks the beats in flight as a queue: valid means "queue not empty",
// ready means "fewer than two beats held", the head output must equal the
// oldest beat in flight, and packet count / write-back request follow from
// the last-beat transfers the model predicts.
// -----------------------------------------------------------------------------
module tb_sde_h2c_axis;

    typedef struct packed {
        logic [511:0] data;
        logic [63:0]  keep;
        logic [63:0]  user;
        logic         last;
    } beat_t;

    logic         clk;
    logic         rst_n;
    logic         cfg_axis_clr_pkt_cnt;
    logic [31:0]  axis_cfg_pkt_cnt;
    logic         axis_cfg_keep_err;
    logic         buf_axis_valid;
    logic [511:0] buf_axis_data;
    logic [63:0]  buf_axis_keep;
    logic [63:0]  buf_axis_user;
    logic         buf_axis_last;
    logic         axis_buf_ready;
    logic         h2c_axis_valid;
    logic [511:0] h2c_axis_data;
    logic [63:0]  h2c_axis_keep;
    logic [63:0]  h2c_axis_user;
    logic         h2c_axis_last;
    logic         h2c_axis_ready;
    logic         axis_wb_pkt_cnt_req;
    logic [31:0]  axis_wb_pkt_cnt;

    sde_h2c_axis dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .cfg_axis_clr_pkt_cnt (cfg_axis_clr_pkt_cnt),
        .axis_cfg_pkt_cnt     (axis_cfg_pkt_cnt),
        .axis_cfg_keep_err    (axis_cfg_keep_err),
        .buf_axis_valid       (buf_axis_valid),
        .buf_axis_data        (buf_axis_data),
        .buf_axis_keep        (buf_axis_keep),
        .buf_axis_user        (buf_axis_user),
        .buf_axis_last        (buf_axis_last),
        .axis_buf_ready       (axis_buf_ready),
        .h2c_axis_valid       (h2c_axis_valid),
        .h2c_axis_data        (h2c_axis_data),
        .h2c_axis_keep        (h2c_axis_keep),
        .h2c_axis_user        (h2c_axis_user),
        .h2c_axis_last        (h2c_axis_last),
        .h2c_axis_ready       (h2c_axis_ready),
        .axis_wb_pkt_cnt_req  (axis_wb_pkt_cnt_req),
        .axis_wb_pkt_cnt      (axis_wb_pkt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // reference model state
    beat_t       q[$];
    logic [31:0] exp_cnt = '0;
    logic        exp_req = 1'b0;
    logic        exp_err = 1'b0;
    logic        was_rst = 1'b1;
    int          req_seen = 0;

    task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic keep_bad(input beat_t b);
        int ones;
        ones = 0;
        for (int i = 0; i < 64; i++) ones += int'(b.keep[i]);
        if (ones == 0) return 1'b1;
        for (int i = 0; i < 64; i++) begin
            if (b.keep[i] != (i < ones)) return 1'b1;
        end
        if (!b.last && ones != 64) return 1'b1;
        return 1'b0;
    endfunction

    function automatic beat_t mk_beat(input logic last, input logic [63:0] keep);
        beat_t b;
        for (int i = 0; i < 16; i++) b.data[i*32 +: 32] = $urandom;
        b.user = {$urandom, $urandom};
        b.keep = keep;
        b.last = last;
        return b;
    endfunction

    function automatic logic [63:0] rand_prefix_keep();
        int n;
        n = $urandom_range(1, 64);
        if (n == 64) return '1;
        return (64'd1 << n) - 64'd1;
    endfunction

    task automatic drive(input logic v, input beat_t b);
        buf_axis_valid = v;
        buf_axis_data  = b.data;
        buf_axis_keep  = b.keep;
        buf_axis_user  = b.user;
        buf_axis_last  = b.last;
    endtask

    // Compare current outputs with the model, predict the next edge, advance
    // one clock. Called at posedge+1 with inputs already driven.
    task automatic step(output logic acc);
        beat_t cur;
        logic  xfer;
        logic  xlast;
        cur = '0;
        cur.data = buf_axis_data;
        cur.keep = buf_axis_keep;
        cur.user = buf_axis_user;
        cur.last = buf_axis_last;

        check("valid", 512'(h2c_axis_valid), 512'(q.size() > 0));
        check("buf_ready", 512'(axis_buf_ready), 512'(!was_rst && q.size() < 2));
        check("req", 512'(axis_wb_pkt_cnt_req), 512'(exp_req));
        check("cfg_cnt", 512'(axis_cfg_pkt_cnt), 512'(exp_cnt));
        check("wb_cnt", 512'(axis_wb_pkt_cnt), 512'(exp_cnt));
        check("keep_err", 512'(axis_cfg_keep_err), 512'(exp_err));
        if (h2c_axis_valid === 1'b1 && q.size() > 0) begin
            check("head_data", h2c_axis_data, q[0].data);
            check("head_side", 512'({h2c_axis_keep, h2c_axis_user, h2c_axis_last}),
                  512'({q[0].keep, q[0].user, q[0].last}));
        end
        if (axis_wb_pkt_cnt_req === 1'b1) req_seen++;

        acc = 1'b0;
        if (!rst_n) begin
            q.delete();
            exp_cnt = '0;
            exp_req = 1'b0;
            exp_err = 1'b0;
            was_rst = 1'b1;
        end else begin
            xfer  = (q.size() > 0) && h2c_axis_ready;
            xlast = xfer && q[0].last;
            acc   = buf_axis_valid && !was_rst && (q.size() < 2);
            if (xfer) void'(q.pop_front());
            if (acc) q.push_back(cur);
            exp_req = xlast;
            if (cfg_axis_clr_pkt_cnt) exp_cnt = '0;
            else if (xlast) exp_cnt = exp_cnt + 32'd1;
`ifdef SDE_H2C_AXIS_KEEP_CHECK_EN
            if (cfg_axis_clr_pkt_cnt) exp_err = 1'b0;
            else if (acc && keep_bad(cur)) exp_err = 1'b1;
`endif
            was_rst = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send_beat(input beat_t b, input logic r);
        logic acc;
        int   n;
        n = 0;
        drive(1'b1, b);
        h2c_axis_ready = r;
        do begin
            step(acc);
            n++;
        end while (!acc && n < 50);
        check("send_timeout", 512'(acc), 512'(1));
        drive(1'b0, b);
    endtask

    task automatic idle(input int n, input logic r);
        logic acc;
        buf_axis_valid = 1'b0;
        h2c_axis_ready = r;
        for (int i = 0; i < n; i++) step(acc);
    endtask

    initial begin
        beat_t b[4];
        beat_t cur;
        logic  acc;
        int    req0;
        int    sent;

        rst_n = 1'b0;
        cfg_axis_clr_pkt_cnt = 1'b0;
        h2c_axis_ready = 1'b0;
        drive(1'b0, '0);
        @(posedge clk);
        #1;

        // reset state
        step(acc);
        step(acc);
        check("rst_data", h2c_axis_data, '0);
        check("rst_side", 512'({h2c_axis_keep, h2c_axis_user, h2c_axis_last}), '0);
        rst_n = 1'b1;
        step(acc);
        check("ready_after_rst", 512'(axis_buf_ready), 512'(1));

        // 3-beat packet, CL always ready
        req0 = req_seen;
        b[0] = mk_beat(1'b0, '1);
        b[1] = mk_beat(1'b0, '1);
        b[2] = mk_beat(1'b1, 64'h0000_0000_0000_FFFF);
        send_beat(b[0], 1'b1);
        check("t3b_latency", h2c_axis_data, b[0].data);
        send_beat(b[1], 1'b1);
        send_beat(b[2], 1'b1);
        idle(3, 1'b1);
        check("t3b_cnt", 512'(axis_cfg_pkt_cnt), 512'(1));
        check("t3b_pulses", 512'(req_seen - req0), 512'(1));

        // backpressure: 4 beats offered, CL not ready
        for (int i = 0; i < 4; i++) b[i] = mk_beat(i == 3, '1);
        send_beat(b[0], 1'b0);
        send_beat(b[1], 1'b0);
        check("bp_ready_low", 512'(axis_buf_ready), 512'(0));
        drive(1'b1, b[2]);
        for (int i = 0; i < 3; i++) begin
            step(acc);
            check("bp_stable", h2c_axis_data, b[0].data);
        end
        send_beat(b[2], 1'b1);
        send_beat(b[3], 1'b1);
        idle(4, 1'b1);
        check("bp_cnt", 512'(axis_cfg_pkt_cnt), 512'(2));

        // 100 random single-beat packets
        cfg_axis_clr_pkt_cnt = 1'b1;
        idle(1, 1'b1);
        cfg_axis_clr_pkt_cnt = 1'b0;
        idle(1, 1'b1);
        req0 = req_seen;
        sent = 0;
        cur  = mk_beat(1'b1, rand_prefix_keep());
        for (int c = 0; c < 4000 && (sent < 100 || q.size() > 0); c++) begin
            drive((sent < 100) && ($urandom_range(0, 3) != 0), cur);
            h2c_axis_ready = ($urandom_range(0, 2) != 0);
            step(acc);
            if (acc) begin
                sent++;
                cur = mk_beat(1'b1, rand_prefix_keep());
            end
        end
        idle(2, 1'b1);
        check("rand_drained", 512'(q.size()), 512'(0));
        check("rand_cnt", 512'(axis_cfg_pkt_cnt), 512'(100));
        check("rand_pulses", 512'(req_seen - req0), 512'(100));

        // count wrap from 0xFFFF_FFFF
        force dut.pkt_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.pkt_cnt_q;
        exp_cnt = 32'hFFFF_FFFF;
        send_beat(mk_beat(1'b1, '1), 1'b1);
        idle(2, 1'b1);
        check("wrap_cnt", 512'(axis_cfg_pkt_cnt), 512'(0));

        // clear coincident with a last transfer
        send_beat(mk_beat(1'b1, '1), 1'b1);
        idle(2, 1'b1);
        send_beat(mk_beat(1'b1, '1), 1'b0);
        cfg_axis_clr_pkt_cnt = 1'b1;
        idle(1, 1'b1);
        cfg_axis_clr_pkt_cnt = 1'b0;
        check("clr_req", 512'(axis_wb_pkt_cnt_req), 512'(1));
        check("clr_cnt", 512'(axis_cfg_pkt_cnt), 512'(0));
        idle(2, 1'b1);

        // reset with skid FULL mid-packet
        send_beat(mk_beat(1'b1, '1), 1'b1);
        idle(2, 1'b1);
        send_beat(mk_beat(1'b0, '1), 1'b0);
        send_beat(mk_beat(1'b1, '1), 1'b0);
        rst_n = 1'b0;
        drive(1'b1, mk_beat(1'b1, '1));
        h2c_axis_ready = 1'b1;
        req0 = req_seen;
        step(acc);
        rst_n = 1'b1;
        drive(1'b0, '0);
        check("rstmid_valid", 512'(h2c_axis_valid), 512'(0));
        check("rstmid_cnt", 512'(axis_cfg_pkt_cnt), 512'(0));
        check("rstmid_ready", 512'(axis_buf_ready), 512'(0));
        step(acc);
        check("rstmid_ready_up", 512'(axis_buf_ready), 512'(1));
        idle(3, 1'b1);
        check("rstmid_no_req", 512'(req_seen - req0), 512'(0));

`ifdef SDE_H2C_AXIS_KEEP_CHECK_EN
        // keep format checking
        send_beat(mk_beat(1'b1, 64'h0000_0000_0000_00FF), 1'b1);
        idle(2, 1'b1);
        check("keep_ok", 512'(axis_cfg_keep_err), 512'(0));
        send_beat(mk_beat(1'b0, 64'h0000_0000_0000_0FFF), 1'b1);
        idle(3, 1'b1);
        check("keep_err_set", 512'(axis_cfg_keep_err), 512'(1));
        send_beat(mk_beat(1'b1, '1), 1'b1);
        idle(2, 1'b1);
        check("keep_err_held", 512'(axis_cfg_keep_err), 512'(1));
        cfg_axis_clr_pkt_cnt = 1'b1;
        idle(1, 1'b1);
        cfg_axis_clr_pkt_cnt = 1'b0;
        check("keep_err_clr", 512'(axis_cfg_keep_err), 512'(0));
        idle(1, 1'b1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
